dma_desc_scheduler: RTL and testbench
=====================================

// Module: dma_desc_scheduler
// PURPOSE
//  Descriptor queue and sequencer in front of dma_func_wrapper. Software/BFM pushes
//  s_dma_desc_t entries into a FIFO. The scheduler launches them one at a time with a
//  one-cycle dma_go_o pulse and waits for done or error. It counts completions and
//  errors, and raises a level interrupt. Replaces the manual go/desc driving in front of the DMA.
// PARAMETERS
//  QUEUE_DEPTH     4       descriptor FIFO entries (power of two, >=2)
//  CNT_W           16      width of done/error counters
//  TIMEOUT_CYCLES  65536   WAIT watchdog limit (only with DMA_SCHED_TIMEOUT_EN)
// PORTS
//  clk          in   1                        clock
//  rstn         in   1                        async active-low reset
//  sched_en_i   in   1                        1 = dispatch allowed; 0 = queue holds
//  desc_valid_i in   1                        push request
//  desc_ready_o out  1                        queue not full
//  desc_i       in   s_dma_desc_t             descriptor to push
//  dma_go_o     out  1                        one-cycle launch pulse to DMA
//  dma_desc_o   out  s_dma_desc_t             descriptor presented to DMA
//  dma_stats_i  in   s_dma_status_t           DMA status; .done = transfer complete
//  dma_error_i  in   s_dma_error_t            DMA error; any nonzero bit = error
//  err_clr_i    in   1                        leave HALT
//  irq_o        out  1                        level irq, set per completion
//  irq_clr_i    in   1                        clear irq_o
//  busy_o       out  1                        state != IDLE
//  q_count_o    out  $clog2(QUEUE_DEPTH+1)    entries queued
//  done_cnt_o   out  CNT_W                    completed transfers (saturating)
//  err_cnt_o    out  CNT_W                    failed transfers (saturating)
//  timeout_o    out  1                        sticky watchdog flag (0 if macro off)
// BEHAVIOUR
//  Reset: all outputs 0, queue flushed, FSM=IDLE. Async assert, sync release on clk.
//  Push: accept when desc_valid_i && desc_ready_o. desc_ready_o = (q_count != DEPTH),
//   computed from registered count. A pop in the same cycle does not free a slot for that push.
//  FSM (registered):
//   IDLE   : sched_en_i && q_count!=0 -> LAUNCH; latch FIFO head into dma_desc_o.
//   LAUNCH : dma_go_o=1 for exactly this cycle; pop FIFO -> WAIT.
//   WAIT   : dma_desc_o held stable. |dma_error_i -> err_cnt++, HALT.
//            Else dma_stats_i.done -> done_cnt++, irq_o<=1, IDLE.
//            Error has priority when error and done are seen together.
//   HALT   : no dispatch; pushes still accepted. err_clr_i -> IDLE.
//  Go-to-go spacing is at least 3 cycles (IDLE, LAUNCH, WAIT). done/error outside WAIT are ignored.
//  sched_en_i deassert during WAIT: current transfer completes; no further launch.
//  Counters saturate at all-ones. irq set and irq_clr_i in the same cycle: set wins.
//  Reset mid-WAIT: scheduler and DMA share rstn. Transfer is abandoned; no count update.
// CONFIGURATION
//  DMA_SCHED_TIMEOUT_EN defined: WAIT cycle counter starts at 0 on entry.
//   Reaching TIMEOUT_CYCLES-1 without done/error -> timeout_o<=1 (sticky until rstn), err_cnt++, HALT.
//   Done/error in that same cycle has priority over the timeout.
//  Undefined: no counter, WAIT waits indefinitely, timeout_o tied 0.
// STRUCTURE
//  dma_pkg gains e_dma_sched_state_t {IDLE,LAUNCH,WAIT,HALT} and DMA_SCHED_CNT_W=16.
//  s_dma_desc_t, s_dma_status_t and s_dma_error_t are reused from dma_pkg.
//  Sub-module dma_desc_fifo: DEPTH x s_dma_desc_t sync FIFO with push/pop/count/full/empty.
//   The FSM, counters, irq and watchdog live in the top module.
// TESTING
//  1 Push 3 descs {src 0x0, dst 0x1100_0000, 0x30}, {0x800, 0x1100_0800, 0x40},
//    {0x1000, 0x1100_1000, 0x80} with sched_en=1, done 10 cycles after each go
//    -> 3 single-cycle go pulses in order, done_cnt=3, q_count=0, irq_o=1.
//  2 sched_en=0, push 5 descs -> desc_ready_o=0 after the 4th, 5th held off, q_count=4, no go.
//  3 dma_error_i nonzero in WAIT -> HALT, err_cnt=1, no go while queue non-empty.
//    Pulse err_clr_i -> next desc launched within 2 cycles.
//  4 done and error in the same cycle -> err_cnt=1, done_cnt=0, irq_o=0, HALT.
//  5 irq_clr_i in the same cycle as a new done -> irq_o stays 1, done_cnt increments.
//  6 With DMA_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=100, no done -> timeout_o=1 and HALT
//    at WAIT cycle 99. Separately, rstn low mid-WAIT -> all outputs 0, q_count=0.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared DMA types: descriptor, status and error records plus the descriptor scheduler state set.
package dma_pkg;

    localparam int DMA_SCHED_CNT_W = 16;

    typedef struct packed {
        logic [31:0] src_addr;
        logic [31:0] dst_addr;
        logic [15:0] xfer_len;
    } s_dma_desc_t;

    typedef struct packed {
        logic busy;
        logic done;
    } s_dma_status_t;

    typedef struct packed {
        logic slv_err;
        logic dec_err;
        logic cfg_err;
    } s_dma_error_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        HALT   = 2'd3
    } e_dma_sched_state_t;

endpackage

// File: rtl/dma_desc_fifo.sv
// DEPTH-entry synchronous FIFO of DMA descriptors; head is visible on dout while not empty.
module dma_desc_fifo
    import dma_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           push,
    input  logic                           pop,
    input  s_dma_desc_t                    din,
    output s_dma_desc_t                    dout,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    s_dma_desc_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/dma_desc_scheduler.sv
// Descriptor queue and one-at-a-time launcher in front of the DMA, with done/error counters and irq.
// Optional WAIT watchdog enabled by defining DMA_SCHED_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for sched_en_i and a queued descriptor
// LAUNCH | dma_go_o high for this cycle, FIFO head popped
// WAIT   | transfer in flight, descriptor held, watching done/error
// HALT   | stopped after an error or timeout until err_clr_i
module dma_desc_scheduler
    import dma_pkg::*;
#(
    parameter int QUEUE_DEPTH    = 4,
    parameter int CNT_W          = DMA_SCHED_CNT_W,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               sched_en_i,
    input  logic                               desc_valid_i,
    output logic                               desc_ready_o,
    input  s_dma_desc_t                        desc_i,
    output logic                               dma_go_o,
    output s_dma_desc_t                        dma_desc_o,
    input  s_dma_status_t                      dma_stats_i,
    input  s_dma_error_t                       dma_error_i,
    input  logic                               err_clr_i,
    output logic                               irq_o,
    input  logic                               irq_clr_i,
    output logic                               busy_o,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   q_count_o,
    output logic [CNT_W-1:0]                   done_cnt_o,
    output logic [CNT_W-1:0]                   err_cnt_o,
    output logic                               timeout_o
);

    logic [1:0]         rst_sync;
    logic               rst_int_n;
    e_dma_sched_state_t state;
    s_dma_desc_t        fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic               stats_unused;

`ifdef DMA_SCHED_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WD_W-1:0] wdog;
    logic            timeout_q;
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    // Async assert, release aligned to clk; the DMA sees the same rstn.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync[1];

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign desc_ready_o = rst_int_n && !fifo_full;
    assign fifo_push    = desc_valid_i && desc_ready_o;
    assign fifo_pop     = (state == LAUNCH);
    assign busy_o       = (state != IDLE);
    assign stats_unused = dma_stats_i.busy;

    dma_desc_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rst_int_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (desc_i),
        .dout  (fifo_head),
        .count (q_count_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state      <= IDLE;
            dma_go_o   <= 1'b0;
            dma_desc_o <= '0;
            irq_o      <= 1'b0;
            done_cnt_o <= '0;
            err_cnt_o  <= '0;
`ifdef DMA_SCHED_TIMEOUT_EN
            wdog       <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            dma_go_o <= 1'b0;
            // A completion later in this block overrides the clear.
            if (irq_clr_i) begin
                irq_o <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (sched_en_i && !fifo_empty) begin
                        state      <= LAUNCH;
                        dma_desc_o <= fifo_head;
                        dma_go_o   <= 1'b1;
                    end
                end
                LAUNCH: begin
                    state <= WAIT;
`ifdef DMA_SCHED_TIMEOUT_EN
                    wdog  <= WD_W'(TIMEOUT_CYCLES - 1);
`endif
                end
                WAIT: begin
                    if (|dma_error_i) begin
                        state <= HALT;
                        if (err_cnt_o != '1) begin
                            err_cnt_o <= err_cnt_o + CNT_W'(1);
                        end
                    end else if (dma_stats_i.done) begin
                        state <= IDLE;
                        irq_o <= 1'b1;
                        if (done_cnt_o != '1) begin
                            done_cnt_o <= done_cnt_o + CNT_W'(1);
                        end
`ifdef DMA_SCHED_TIMEOUT_EN
                    end else if (wdog == '0) begin
                        state     <= HALT;
                        timeout_q <= 1'b1;
                        if (err_cnt_o != '1) begin
                            err_cnt_o <= err_cnt_o + CNT_W'(1);
                        end
                    end else begin
                        wdog <= wdog - WD_W'(1);
`endif
                    end
                end
                HALT: begin
                    if (err_clr_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_desc_scheduler.sv
// Scoreboarded bench for dma_desc_scheduler: expected descriptors are queued on push and
// checked by a monitor on every go pulse; a DMA responder model tracks expected counts.
module tb_dma_desc_scheduler;
    import dma_pkg::*;

    localparam int QD  = 4;
    localparam int CW  = 4;
    localparam int TOC = 100;

    logic          clk;
    logic          rstn;
    logic          sched_en_i;
    logic          desc_valid_i;
    logic          desc_ready_o;
    s_dma_desc_t   desc_i;
    logic          dma_go_o;
    s_dma_desc_t   dma_desc_o;
    s_dma_status_t dma_stats_i;
    s_dma_error_t  dma_error_i;
    logic          err_clr_i;
    logic          irq_o;
    logic          irq_clr_i;
    logic          busy_o;
    logic [2:0]    q_count_o;
    logic [CW-1:0] done_cnt_o;
    logic [CW-1:0] err_cnt_o;
    logic          timeout_o;

    dma_desc_scheduler #(
        .QUEUE_DEPTH    (QD),
        .CNT_W          (CW),
        .TIMEOUT_CYCLES (TOC)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .sched_en_i   (sched_en_i),
        .desc_valid_i (desc_valid_i),
        .desc_ready_o (desc_ready_o),
        .desc_i       (desc_i),
        .dma_go_o     (dma_go_o),
        .dma_desc_o   (dma_desc_o),
        .dma_stats_i  (dma_stats_i),
        .dma_error_i  (dma_error_i),
        .err_clr_i    (err_clr_i),
        .irq_o        (irq_o),
        .irq_clr_i    (irq_clr_i),
        .busy_o       (busy_o),
        .q_count_o    (q_count_o),
        .done_cnt_o   (done_cnt_o),
        .err_cnt_o    (err_cnt_o),
        .timeout_o    (timeout_o)
    );

    int tests = 0;
    int fails = 0;
    s_dma_desc_t exp_q[$];
    int go_total = 0;
    int exp_done_n = 0;
    int exp_err_n = 0;
    int halt_cnt = 0;
    int clr_cnt = 0;
    int base_done = 0;
    int base_err = 0;
    int bfm_mode = 0;   // 0 done, 1 error, 2 done+error, 3 silent, 4 random
    int bfm_lat = 10;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic int sat(input int n);
        return (n > (1 << CW) - 1) ? (1 << CW) - 1 : n;
    endfunction

    function automatic s_dma_desc_t rand_desc();
        s_dma_desc_t d;
        d.src_addr = $urandom;
        d.dst_addr = $urandom;
        d.xfer_len = 16'($urandom);
        return d;
    endfunction

    function automatic s_dma_desc_t mk(input logic [31:0] s, input logic [31:0] t, input logic [15:0] l);
        s_dma_desc_t d;
        d.src_addr = s;
        d.dst_addr = t;
        d.xfer_len = l;
        return d;
    endfunction

    // Scoreboard monitor: every go pulse must present the oldest accepted descriptor.
    initial begin
        logic prev_go;
        s_dma_desc_t e;
        prev_go = 1'b0;
        forever begin
            @(negedge clk);
            if (dma_go_o === 1'b1) begin
                go_total++;
                check("go_single_cycle", 80'(prev_go), 80'(0));
                if (exp_q.size() == 0) begin
                    check("go_unexpected", 80'(dma_go_o), 80'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("go_desc", 80'(dma_desc_o), 80'(e));
                end
            end
            prev_go = dma_go_o;
        end
    end

    // DMA responder model; expected counts follow from the response it chooses.
    initial begin
        dma_stats_i = '0;
        dma_error_i = '0;
        forever begin
            @(negedge clk);
            if (dma_go_o === 1'b1 && rstn && bfm_mode != 3) begin
                int kind;
                int lat;
                int r;
                kind = bfm_mode;
                lat  = bfm_lat;
                if (kind == 4) begin
                    lat  = $urandom_range(1, 8);
                    r    = $urandom_range(0, 9);
                    kind = (r < 8) ? 0 : ((r == 8) ? 1 : 2);
                end
                repeat (lat) @(negedge clk);
                if (rstn) begin
                    if (kind != 1) dma_stats_i.done = 1'b1;
                    if (kind != 0) dma_error_i = s_dma_error_t'(3'($urandom_range(1, 7)));
                    if (kind == 0) exp_done_n++;
                    else exp_err_n++;
                    @(negedge clk);
                    dma_stats_i = '0;
                    dma_error_i = '0;
                    if (kind != 0) halt_cnt++;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_go"}, 80'(dma_go_o), 80'(0));
        check({tag, "_desc"}, 80'(dma_desc_o), 80'(0));
        check({tag, "_irq"}, 80'(irq_o), 80'(0));
        check({tag, "_busy"}, 80'(busy_o), 80'(0));
        check({tag, "_qcount"}, 80'(q_count_o), 80'(0));
        check({tag, "_done_cnt"}, 80'(done_cnt_o), 80'(0));
        check({tag, "_err_cnt"}, 80'(err_cnt_o), 80'(0));
        check({tag, "_timeout"}, 80'(timeout_o), 80'(0));
        check({tag, "_ready"}, 80'(desc_ready_o), 80'(0));
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        sched_en_i = 1'b0;
        desc_valid_i = 1'b0;
        err_clr_i = 1'b0;
        irq_clr_i = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        exp_q.delete();
        base_done = exp_done_n;
        base_err = exp_err_n;
        clr_cnt = halt_cnt;
        rstn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic push(input s_dma_desc_t d);
        bit ok;
        ok = 1'b0;
        desc_i = d;
        desc_valid_i = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (desc_ready_o) begin
                exp_q.push_back(d);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        desc_valid_i = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: ready stayed 0, required 1");
        end
    endtask

    task automatic wait_go(input int budget, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (dma_go_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(nm, 80'(ok), 80'(1));
    endtask

    task automatic wait_idle(input int budget, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            err_clr_i = 1'b0;
            if (!busy_o && q_count_o == 0) begin
                ok = 1'b1;
                break;
            end
            if (halt_cnt != clr_cnt) begin
                err_clr_i = 1'b1;
                clr_cnt++;
            end
            @(negedge clk);
        end
        err_clr_i = 1'b0;
        check(nm, 80'(ok), 80'(1));
    endtask

    task automatic wait_halt(input int budget, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (halt_cnt != clr_cnt) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        check(nm, 80'(ok), 80'(1));
    endtask

    initial begin
        int g0;
        int npush;
        bit found;
        rstn = 1'b1;
        sched_en_i = 1'b0;
        desc_valid_i = 1'b0;
        desc_i = '0;
        err_clr_i = 1'b0;
        irq_clr_i = 1'b0;
        @(negedge clk);
        do_reset();
        check("ready_after_reset", 80'(desc_ready_o), 80'(1));

        // 1: three descriptors dispatched in order
        bfm_mode = 0;
        bfm_lat = 10;
        sched_en_i = 1'b1;
        g0 = go_total;
        push(mk(32'h0, 32'h1100_0000, 16'h30));
        push(mk(32'h800, 32'h1100_0800, 16'h40));
        push(mk(32'h1000, 32'h1100_1000, 16'h80));
        wait_idle(200, "t1_idle");
        check("t1_go_count", 80'(go_total - g0), 80'(3));
        check("t1_done_cnt", 80'(done_cnt_o), 80'(3));
        check("t1_qcount", 80'(q_count_o), 80'(0));
        check("t1_irq", 80'(irq_o), 80'(1));
        check("t1_sb_empty", 80'(exp_q.size()), 80'(0));

        // 2: queue fills with dispatch disabled
        do_reset();
        g0 = go_total;
        for (int i = 0; i < QD; i++) push(rand_desc());
        check("t2_ready_full", 80'(desc_ready_o), 80'(0));
        check("t2_qcount", 80'(q_count_o), 80'(4));
        desc_i = rand_desc();
        desc_valid_i = 1'b1;
        found = 1'b0;
        repeat (5) begin
            if (desc_ready_o) found = 1'b1;
            @(negedge clk);
        end
        desc_valid_i = 1'b0;
        check("t2_fifth_held", 80'(found), 80'(0));
        check("t2_qcount_after", 80'(q_count_o), 80'(4));
        check("t2_no_go", 80'(go_total - g0), 80'(0));

        // 3: error halts dispatch until err_clr_i
        do_reset();
        bfm_mode = 1;
        bfm_lat = 3;
        sched_en_i = 1'b1;
        push(rand_desc());
        push(rand_desc());
        wait_halt(100, "t3_halt_seen");
        bfm_mode = 0;
        g0 = go_total;
        repeat (20) @(negedge clk);
        check("t3_no_go_halted", 80'(go_total - g0), 80'(0));
        check("t3_err_cnt", 80'(err_cnt_o), 80'(1));
        check("t3_busy", 80'(busy_o), 80'(1));
        check("t3_qcount", 80'(q_count_o), 80'(1));
        err_clr_i = 1'b1;
        clr_cnt++;
        @(negedge clk);
        err_clr_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (dma_go_o) found = 1'b1;
            if (!found) @(negedge clk);
        end
        check("t3_relaunch_2cyc", 80'(found), 80'(1));
        wait_idle(100, "t3_idle");
        check("t3_done_cnt", 80'(done_cnt_o), 80'(1));

        // 4: done and error together -> error wins
        do_reset();
        bfm_mode = 2;
        bfm_lat = 5;
        sched_en_i = 1'b1;
        push(rand_desc());
        wait_halt(100, "t4_halt_seen");
        check("t4_err_cnt", 80'(err_cnt_o), 80'(1));
        check("t4_done_cnt", 80'(done_cnt_o), 80'(0));
        check("t4_irq", 80'(irq_o), 80'(0));
        check("t4_busy_halt", 80'(busy_o), 80'(1));

        // 5: irq set beats a coincident irq_clr_i
        do_reset();
        bfm_mode = 0;
        bfm_lat = 4;
        sched_en_i = 1'b1;
        push(rand_desc());
        wait_idle(100, "t5_idle1");
        check("t5_irq_first", 80'(irq_o), 80'(1));
        push(rand_desc());
        wait_go(20, "t5_go_seen");
        repeat (4) @(negedge clk);
        irq_clr_i = 1'b1;
        @(negedge clk);
        irq_clr_i = 1'b0;
        check("t5_irq_set_wins", 80'(irq_o), 80'(1));
        check("t5_done_cnt", 80'(done_cnt_o), 80'(2));
        irq_clr_i = 1'b1;
        @(negedge clk);
        irq_clr_i = 1'b0;
        check("t5_irq_cleared", 80'(irq_o), 80'(0));

        // 6: watchdog (or its absence) with a silent DMA
        do_reset();
        bfm_mode = 3;
        sched_en_i = 1'b1;
        push(rand_desc());
        wait_go(20, "t6_go_seen");
`ifdef DMA_SCHED_TIMEOUT_EN
        repeat (TOC) @(negedge clk);
        check("t6_no_timeout_early", 80'(timeout_o), 80'(0));
        check("t6_err_before", 80'(err_cnt_o), 80'(0));
        @(negedge clk);
        check("t6_timeout", 80'(timeout_o), 80'(1));
        check("t6_err_cnt", 80'(err_cnt_o), 80'(1));
        check("t6_busy_halt", 80'(busy_o), 80'(1));
        g0 = go_total;
        push(rand_desc());
        repeat (10) @(negedge clk);
        check("t6_no_go_halted", 80'(go_total - g0), 80'(0));
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        wait_go(5, "t6_relaunch");
        check("t6_timeout_sticky", 80'(timeout_o), 80'(1));
`else
        repeat (TOC + 50) @(negedge clk);
        check("t6_no_timeout", 80'(timeout_o), 80'(0));
        check("t6_still_waiting", 80'(busy_o), 80'(1));
        check("t6_err_none", 80'(err_cnt_o), 80'(0));
`endif

        // reset in the middle of WAIT abandons the transfer
        do_reset();
        bfm_mode = 3;
        sched_en_i = 1'b1;
        push(rand_desc());
        push(rand_desc());
        wait_go(20, "rst_go_seen");
        repeat (5) @(negedge clk);
        check("rst_busy_pre", 80'(busy_o), 80'(1));
        rstn = 1'b0;
        #1;
        check_reset_outputs("midwait");
        do_reset();
        check("rst_ready_after", 80'(desc_ready_o), 80'(1));
        check("rst_idle_after", 80'(busy_o), 80'(0));

        // randomized traffic against the model, counters allowed to saturate
        bfm_mode = 4;
        npush = 0;
        g0 = go_total;
        for (int c = 0; c < 1500; c++) begin
            sched_en_i = ($urandom_range(0, 9) != 0);
            desc_valid_i = ($urandom_range(0, 2) == 0);
            desc_i = rand_desc();
            if (desc_valid_i && desc_ready_o) begin
                exp_q.push_back(desc_i);
                npush++;
            end
            err_clr_i = 1'b0;
            if (halt_cnt != clr_cnt && $urandom_range(0, 3) == 0) begin
                err_clr_i = 1'b1;
                clr_cnt++;
            end
            @(negedge clk);
        end
        desc_valid_i = 1'b0;
        err_clr_i = 1'b0;
        sched_en_i = 1'b1;
        wait_idle(1000, "rand_drain");
        check("rand_go_count", 80'(go_total - g0), 80'(npush));
        check("rand_sb_empty", 80'(exp_q.size()), 80'(0));
        check("rand_done_cnt", 80'(done_cnt_o), 80'(sat(exp_done_n - base_done)));
        check("rand_err_cnt", 80'(err_cnt_o), 80'(sat(exp_err_n - base_err)));
        check("rand_irq", 80'(irq_o), 80'(exp_done_n > base_done));
        check("rand_qcount", 80'(q_count_o), 80'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
